// File: rtl/seg_pkg.sv
// Shared constants and helpers for the four-digit multiplexed seven-segment
// scan controller. Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int          NUM_DIGITS          = 4;
    localparam int          REFRESH_DIV_DEFAULT = 50000;
    localparam logic [6:0]  SEG_BLANK           = 7'b1111111;
    localparam logic [6:0]  SEG_DASH            = 7'b0111111;

    // Active-low anode pattern that enables only digit slot idx.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] idx);
        anode_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// BCD nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
// Values 10..15 are not decimal digits and show a lone middle bar (dash).
module seg_scan_ctrl_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup; every path assigns o_seg so no storage is implied.
    always_comb begin
        // NOTE: the default assignment first guarantees no latch even if a case arm is missed.
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = 7'b1000000;
            4'd1: o_seg = 7'b1111001;
            4'd2: o_seg = 7'b0100100;
            4'd3: o_seg = 7'b0110000;
            4'd4: o_seg = 7'b0011001;
            4'd5: o_seg = 7'b0010010;
            4'd6: o_seg = 7'b0000010;
            4'd7: o_seg = 7'b1111000;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0010000;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller.
// A prescaler paces one digit slot every REFRESH_DIV clocks; new Digits are
// staged in a pending register and only promoted to the displayed (active)
// register at a frame boundary, so a frame never shows a mix of old and new.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zeros on
// digits 1..3 (digit 0 always shown).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        En,
    input  logic        Load,
    input  logic [15:0] Digits,
    output logic        Ack,
    output logic [6:0]  Seg,
    output logic [3:0]  An
);

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_active;
    logic [15:0] r_pending;
    logic        r_pend_vld;
    logic        r_ack;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;

    logic        w_tick;
    logic        w_frame_end;
    logic [3:0]  w_nibble;
    logic [6:0]  w_dec_seg;
    logic        w_lz_blank;

    assign w_tick      = (r_cnt == 16'(REFRESH_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == 2'd3);
    assign w_nibble    = r_active[{r_idx, 2'b00} +: 4];

    // Single decoder shared by all slots; the scan index picks its input.
    seg_scan_ctrl_dec u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank the current slot when it and every more significant digit are zero.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd1:    w_lz_blank = (r_active[15:4]  == 12'd0);
            2'd2:    w_lz_blank = (r_active[15:8]  == 8'd0);
            2'd3:    w_lz_blank = (r_active[15:12] == 4'd0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Prescaler and digit index run freely, independent of En.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 16'd1;
            if (w_tick)
                r_idx <= r_idx + 2'd1;
        end
    end

    // Load/Ack handshake: stage mid-frame, promote only at a frame boundary.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so a reset mid-frame discards any staged value.
        if (!rst_n) begin
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_ack      <= 1'b0;
        end else if (w_frame_end) begin
            if (Load) begin
                r_active   <= Digits;
                r_pend_vld <= 1'b0;
                r_ack      <= 1'b1;
            end else if (r_pend_vld) begin
                r_active   <= r_pending;
                r_pend_vld <= 1'b0;
                r_ack      <= 1'b1;
            end else begin
                r_ack      <= 1'b0;
            end
        end else begin
            r_ack <= 1'b0;
            if (Load) begin
                r_pending  <= Digits;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind idx/active.
    always_ff @(posedge clk) begin
        if (!rst_n || !En) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_lz_blank ? SEG_BLANK : w_dec_seg;
            r_an  <= anode_sel(r_idx);
        end
    end

    assign Ack = r_ack;
    assign Seg = r_seg;
    assign An  = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl at REFRESH_DIV=4. A behavioural model
// derives scan position from the number of clocks since reset and applies the
// Load/Ack rules directly; directed scenarios add literal checks on top of a
// randomized soak. Build with +define+SEG_LEADING_ZERO_BLANK_EN to test blanking.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] digits = '0;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int          m_k = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pend   = '0;
    bit          m_pend_vld = 1'b0;
    logic        m_ack = 1'b0;
    logic [6:0]  m_seg = SEG_BLANK;
    logic [3:0]  m_an  = 4'hF;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (en),
        .Load   (load),
        .Digits (digits),
        .Ack    (ack),
        .Seg    (seg),
        .An     (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_digit(input logic [15:0] word, input int pos);
        int nib;
        nib = int'((word >> (4 * pos)) & 16'h000F);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (pos > 0 && (word >> (4 * pos)) == 16'd0)
            return SEG_BLANK;
`endif
        if (nib > 9)
            return 7'b0111111;
        return SEG_TAB[nib];
    endfunction

    // One clock: update the model from the inputs seen at the edge, then
    // compare all outputs half a cycle later.
    task automatic cycle();
        int  idx;
        bit  boundary;
        @(posedge clk);
        if (!rst_n) begin
            m_k = 0;
            m_active = '0;
            m_pend = '0;
            m_pend_vld = 1'b0;
            m_ack = 1'b0;
            m_seg = SEG_BLANK;
            m_an = 4'hF;
        end else begin
            idx      = (m_k / DIV) % 4;
            boundary = (m_k % FRAME) == FRAME - 1;
            m_an     = en ? ~(4'b0001 << idx) : 4'hF;
            m_seg    = en ? ref_digit(m_active, idx) : SEG_BLANK;
            m_ack    = 1'b0;
            if (boundary) begin
                if (load) begin
                    m_active = digits; m_pend_vld = 1'b0; m_ack = 1'b1;
                end else if (m_pend_vld) begin
                    m_active = m_pend; m_pend_vld = 1'b0; m_ack = 1'b1;
                end
            end else if (load) begin
                m_pend = digits; m_pend_vld = 1'b1;
            end
            m_k++;
        end
        @(negedge clk);
        check("ack", ack, m_ack);
        check("an",  an,  m_an);
        check("seg", seg, m_seg);
    endtask

    // Advance until the next edge will see prescaler/index position p of the frame.
    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((m_k % FRAME) == p) return;
            cycle();
        end
    endtask

    task automatic pulse_load(input logic [15:0] d);
        load = 1'b1;
        digits = d;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            n++;
            if (ack === 1'b1) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic count_acks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            cycle();
            if (ack === 1'b1) n++;
        end
    endtask

    task automatic seg_at(input string tag, input logic [3:0] anode, input logic [6:0] exp);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            if (an === anode) begin
                check(tag, seg, exp);
                return;
            end
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [3:0] walk [5];
        logic [6:0] lead_exp;
        int n;
        walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset state.
        for (int i = 0; i < 3; i++) cycle();
        check("rst_seg", seg, 7'b1111111);
        check("rst_an",  an,  4'b1111);
        check("rst_ack", ack, 0);

        // Anode walk after release.
        rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            cycle();
            if (i % 4 == 0) check("an_walk", an, walk[i / 4]);
        end

        // Mid-frame Load: Ack ten clocks later, at the boundary.
        wait_phase(5);
        pulse_load(16'h1234);
        wait_ack("hs", n);
        check("hs_latency", n, 10);
        seg_at("hs_d0", 4'b1110, 7'b0011001);
        seg_at("hs_d3", 4'b0111, 7'b1111001);

        // Latest wins: two Loads in one frame, one Ack, second value shown.
        wait_phase(2);
        pulse_load(16'h1111);
        wait_phase(6);
        pulse_load(16'h2222);
        count_acks(20, n);
        check("lw_acks", n, 1);
        seg_at("lw_d0", 4'b1110, 7'b0100100);

        // Load on the boundary: immediate Ack, nothing left pending.
        wait_phase(FRAME - 1);
        load = 1'b1;
        digits = 16'h5678;
        cycle();
        load = 1'b0;
        check("bnd_ack", ack, 1);
        count_acks(FRAME, n);
        check("bnd_no_extra_ack", n, 0);
        seg_at("bnd_d0", 4'b1110, 7'b0000000);

        // Leading zeros.
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lead_exp = 7'b1111111;
`else
        lead_exp = 7'b1000000;
`endif
        wait_phase(4);
        pulse_load(16'h0050);
        wait_ack("lz", n);
        seg_at("lz_d3", 4'b0111, lead_exp);
        seg_at("lz_d2", 4'b1011, lead_exp);
        seg_at("lz_d1", 4'b1101, 7'b0010010);
        seg_at("lz_d0", 4'b1110, 7'b1000000);

        // Display disabled: handshake keeps running, outputs blank.
        en = 1'b0;
        wait_phase(1);
        pulse_load(16'hABCF);
        wait_ack("en0", n);
        check("en0_latency", n, 14);
        check("en0_an",  an,  4'b1111);
        check("en0_seg", seg, 7'b1111111);
        en = 1'b1;
        seg_at("dash_d0", 4'b1110, 7'b0111111);
        seg_at("dash_d1", 4'b1101, 7'b0111111);
        seg_at("dash_d2", 4'b1011, 7'b0111111);
        seg_at("dash_d3", 4'b0111, 7'b0111111);

        // Reset mid-frame drops the staged value; Load during reset ignored.
        wait_phase(3);
        pulse_load(16'h9999);
        wait_phase(8);
        rst_n = 1'b0;
        load = 1'b1;
        digits = 16'h7777;
        cycle();
        cycle();
        load = 1'b0;
        rst_n = 1'b1;
        count_acks(20, n);
        check("rst_mid_acks", n, 0);
        seg_at("rst_mid_d0", 4'b1110, 7'b1000000);
        seg_at("rst_mid_d3", 4'b0111, lead_exp);

        // Randomized soak against the model.
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(7) != 0);
            load   = ($urandom_range(5) == 0);
            digits = 16'($urandom);
            rst_n  = ($urandom_range(199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        load = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
